// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART blocks.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data is valid whenever !empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
   assign push = wr_en && !full;
   assign pop  = rd_en && !empty;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO drained by a baud-rate FSM onto a registered tx pin.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ  = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int BUFFER_SIZE = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_en,
   input  logic [7:0]                         wr_data,
   output logic                               full,
   output logic                               empty,
   output logic [$clog2(BUFFER_SIZE+1)-1:0]   count,
   output logic                               busy,
   output logic                               tx
);

   localparam int            CPB       = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int            BW        = $clog2(CPB);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   uart_tx_state_t state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           pop, baud_end;
   logic [7:0]     fifo_data;

   sync_fifo #(.WIDTH(8), .DEPTH(BUFFER_SIZE)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign baud_end = (baud_q == BAUD_LAST);
   assign busy     = (state_q != IDLE);
   assign tx       = tx_q;

   // tx_d is the value the line takes in the next state, so tx stays a pure flop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               baud_d  = '0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            baud_d = baud_q + BW'(1);
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            baud_d = baud_q + BW'(1);
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
         STOP: begin
            baud_d = baud_q + BW'(1);
            if (baud_end) begin
               baud_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_data;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule
